adc_loopback_tester: RTL and testbench

Parametrised DAC-stimulus / ADC-response test sequencer for the board self-test path. It powers the analogue front end, drives a stimulus word to the DAC, waits for the ADC response with a timeout, and compares the response against a masked expected value. It supports single, counted and continuous runs with saturating error and timeout statistics. It sits between the test-control register block and the DAC/ADC interface wrappers.

---
 rtl/adc_loopback_tester.sv | 150 +++++++++++++++
 tb/tb_adc_loopback_tester.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_loopback_tester.sv
// rtl/adc_loopback_tester.sv - DAC stimulus / ADC response self-test sequencer
// Optional: PATTERN_INC_EN adds iter_count to the stimulus and expected words.
module adc_loopback_tester #(
    parameter int DW         = 16,
    parameter int CNT_W      = 32,
    parameter int ERR_W      = 16,
    parameter int TO_W       = 16,
    parameter int PWR_SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] max_cycles,
    input  logic [TO_W-1:0]  timeout_cycles,
    input  logic [DW-1:0]    stim_pattern,
    input  logic [DW-1:0]    expect_pattern,
    input  logic [DW-1:0]    expect_mask,
    input  logic [DW-1:0]    adc_data,
    input  logic             adc_valid,
    output logic [DW-1:0]    dac_data,
    output logic             dac_valid,
    output logic             power_en,
    output logic             busy,
    output logic             test_done,
    output logic [CNT_W-1:0] iter_count,
    output logic [ERR_W-1:0] error_count,
    output logic             timeout_seen
);

    typedef enum logic [2:0] {IDLE, PWR_UP, DRIVE, WAIT_RSP, DONE} state_t;

    localparam int SW = (PWR_SETTLE < 2) ? 1 : $clog2(PWR_SETTLE);
    localparam bit NO_SETTLE_STATE = (PWR_SETTLE == 1);

    state_t            state, next_state;
    logic [SW-1:0]     settle_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  max_q;
    logic [TO_W-1:0]   to_q;
    logic [DW-1:0]     stim_q, exp_q, mask_q;
    logic [DW-1:0]     stim_word, exp_word;
    logic [CNT_W-1:0]  iter_inc;
    logic [TO_W:0]     to_next;
    logic              start_ok, timed_out, mismatch, iter_last, settle_done, resolve;

`ifdef PATTERN_INC_EN
    assign stim_word = stim_q + DW'(iter_count);
    assign exp_word  = exp_q + DW'(iter_count);
`else
    assign stim_word = stim_q;
    assign exp_word  = exp_q;
`endif

    assign start_ok    = start && !abort && (mode != 2'b11);
    assign to_next     = {1'b0, to_cnt} + {{TO_W{1'b0}}, 1'b1};
    assign timed_out   = !adc_valid && (to_q != '0) && (to_next == {1'b0, to_q});
    assign mismatch    = |((adc_data ^ exp_word) & mask_q);
    assign iter_inc    = iter_count + {{(CNT_W-1){1'b0}}, 1'b1};
    assign iter_last   = (mode_q == 2'b00) || ((mode_q == 2'b01) && (iter_inc == max_q));
    // The strobe is registered one cycle behind DRIVE, so PWR_UP holds PWR_SETTLE-1 cycles.
    assign settle_done = (32'(settle_cnt) + 32'd2) >= PWR_SETTLE;
    assign resolve     = (state == WAIT_RSP) && !abort && (adc_valid || timed_out);

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    if (NO_SETTLE_STATE && !((mode == 2'b01) && (max_cycles == '0)))
                        next_state = DRIVE;
                    else
                        next_state = PWR_UP;
                end
            end
            PWR_UP: begin
                if (abort)
                    next_state = IDLE;
                else if ((mode_q == 2'b01) && (max_q == '0))
                    next_state = DONE;
                else if (settle_done)
                    next_state = DRIVE;
            end
            DRIVE:    next_state = abort ? IDLE : WAIT_RSP;
            WAIT_RSP: begin
                if (abort)
                    next_state = IDLE;
                else if (adc_valid || timed_out)
                    next_state = iter_last ? DONE : DRIVE;
            end
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            to_cnt       <= '0;
            mode_q       <= '0;
            max_q        <= '0;
            to_q         <= '0;
            stim_q       <= '0;
            exp_q        <= '0;
            mask_q       <= '0;
            dac_data     <= '0;
            dac_valid    <= 1'b0;
            power_en     <= 1'b0;
            busy         <= 1'b0;
            test_done    <= 1'b0;
            iter_count   <= '0;
            error_count  <= '0;
            timeout_seen <= 1'b0;
        end else begin
            state      <= next_state;
            busy       <= (next_state == PWR_UP) || (next_state == DRIVE) || (next_state == WAIT_RSP);
            power_en   <= (next_state == PWR_UP) || (next_state == DRIVE) || (next_state == WAIT_RSP);
            test_done  <= (next_state == DONE);
            dac_valid  <= (state == DRIVE) && !abort;
            settle_cnt <= (state == PWR_UP) ? settle_cnt + SW'(1) : '0;
            to_cnt     <= (state == WAIT_RSP) ? to_cnt + TO_W'(1) : '0;

            if ((state == DRIVE) && !abort)
                dac_data <= stim_word;

            if (((state == IDLE) || (state == DONE)) && start_ok) begin
                mode_q       <= mode;
                max_q        <= max_cycles;
                to_q         <= timeout_cycles;
                stim_q       <= stim_pattern;
                exp_q        <= expect_pattern;
                mask_q       <= expect_mask;
                iter_count   <= '0;
                error_count  <= '0;
                timeout_seen <= 1'b0;
            end

            if (resolve) begin
                iter_count <= iter_inc;
                if ((timed_out || mismatch) && (error_count != '1))
                    error_count <= error_count + ERR_W'(1);
                if (timed_out)
                    timeout_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_loopback_tester.sv
// tb/tb_adc_loopback_tester.sv - directed vector bench for adc_loopback_tester
module tb_adc_loopback_tester;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] max_cycles = '0;
    logic [15:0] timeout_cycles = '0;
    logic [15:0] stim_pattern = '0;
    logic [15:0] expect_pattern = '0;
    logic [15:0] expect_mask = '0;
    logic [15:0] adc_data = '0;
    logic        adc_valid = 1'b0;

    logic [15:0] dac_data, s_dac_data;
    logic        dac_valid, power_en, busy, test_done, timeout_seen;
    logic        s_dac_valid, s_power_en, s_busy, s_test_done, s_timeout_seen;
    logic [31:0] iter_count, s_iter_count;
    logic [15:0] error_count;
    logic [1:0]  s_error_count;

    int checks = 0;
    int errors = 0;

    adc_loopback_tester dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .max_cycles(max_cycles), .timeout_cycles(timeout_cycles),
        .stim_pattern(stim_pattern), .expect_pattern(expect_pattern),
        .expect_mask(expect_mask), .adc_data(adc_data), .adc_valid(adc_valid),
        .dac_data(dac_data), .dac_valid(dac_valid), .power_en(power_en),
        .busy(busy), .test_done(test_done), .iter_count(iter_count),
        .error_count(error_count), .timeout_seen(timeout_seen)
    );

    adc_loopback_tester #(.ERR_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .max_cycles(max_cycles), .timeout_cycles(timeout_cycles),
        .stim_pattern(stim_pattern), .expect_pattern(expect_pattern),
        .expect_mask(expect_mask), .adc_data(adc_data), .adc_valid(adc_valid),
        .dac_data(s_dac_data), .dac_valid(s_dac_valid), .power_en(s_power_en),
        .busy(s_busy), .test_done(s_test_done), .iter_count(s_iter_count),
        .error_count(s_error_count), .timeout_seen(s_timeout_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] max;
        logic [15:0] to;
        logic [15:0] stim;
        logic [15:0] expv;
        logic [15:0] mask;
        logic [15:0] bad;
        int          bad_iters;
        bit          respond;
        int          exp_iter;
        int          exp_err;
        bit          exp_to;
        int          exp_dv;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  dv;
        bit  done;
        dv   = 0;
        done = 1'b0;
        @(negedge clk);
        mode = v.mode; max_cycles = v.max; timeout_cycles = v.to;
        stim_pattern = v.stim; expect_pattern = v.expv; expect_mask = v.mask;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            adc_valid = 1'b0;
            if (test_done) begin
                done = 1'b1;
            end else if (dac_valid) begin
                dv++;
                if (v.respond) begin
                    adc_valid = 1'b1;
                    adc_data  = (((v.bad_iters >> (dv - 1)) & 1) != 0) ? v.bad : v.expv;
                end
            end
        end
        adc_valid = 1'b0;
        check($sformatf("v%0d_done", idx), 64'(done), 64'd1);
        check($sformatf("v%0d_iter", idx), 64'(iter_count), 64'(v.exp_iter));
        check($sformatf("v%0d_err", idx), 64'(error_count), 64'(v.exp_err));
        check($sformatf("v%0d_tmo", idx), 64'(timeout_seen), 64'(v.exp_to));
        check($sformatf("v%0d_dv", idx), 64'(dv), 64'(v.exp_dv));
        check($sformatf("v%0d_idle", idx), {62'd0, busy, power_en}, 64'd0);
    endtask

    initial begin : main
        int          k;
        int          got;
        logic [15:0] seen[3];
        logic [15:0] want[3];

        //          mode   max    to     stim     exp      mask     bad      bits resp iter err to dv
        vecs[0] = '{2'b00, 32'd0, 16'd0, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, 0,  1, 1, 0, 0, 1};
        vecs[1] = '{2'b01, 32'd5, 16'd0, 16'hAAAA, 16'h5555, 16'hFFFE, 16'h5554, 10, 1, 5, 0, 0, 5};
        vecs[2] = '{2'b01, 32'd5, 16'd0, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h5554, 10, 1, 5, 2, 0, 5};
        vecs[3] = '{2'b01, 32'd5, 16'd3, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, 0,  0, 5, 5, 1, 5};
        vecs[4] = '{2'b01, 32'd0, 16'd3, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000, 0,  0, 0, 0, 0, 0};
        vecs[5] = '{2'b00, 32'd0, 16'd10, 16'h1234, 16'h00F0, 16'h00FF, 16'h00F1, 1, 1, 1, 1, 0, 1};
        vecs[6] = '{2'b00, 32'd0, 16'd0, 16'h1234, 16'h0000, 16'h0000, 16'hFFFF, 1,  1, 1, 0, 0, 1};

        repeat (3) @(negedge clk);
        check("rst_outputs", {dac_data, 32'(iter_count[15:0]), error_count},
              64'd0);
        check("rst_flags", {59'd0, dac_valid, power_en, busy, test_done, timeout_seen}, 64'd0);
        rst_n = 1'b1;

        // Power-up to first strobe latency and response-to-next-strobe latency
        @(negedge clk);
        mode = 2'b01; max_cycles = 32'd3; timeout_cycles = '0;
        stim_pattern = 16'hFFFE; expect_pattern = 16'h0000; expect_mask = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", {62'd0, busy, power_en}, 64'd3);
        k = 1;
        while (!dac_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("first_dv_latency", 64'(k), 64'd5);
        seen[0] = dac_data;
        adc_valid = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
        check("rsp_iter_r1", 64'(iter_count), 64'd1);
        check("rsp_dv_r1", 64'(dac_valid), 64'd0);
        @(negedge clk);
        check("rsp_dv_r2", 64'(dac_valid), 64'd1);
        seen[1] = dac_data;
        adc_valid = 1'b1;
        got = 2;
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk);
            adc_valid = 1'b0;
            if (dac_valid) begin
                seen[got] = dac_data;
                got++;
                adc_valid = 1'b1;
            end
        end
        @(negedge clk);
        adc_valid = 1'b0;
`ifdef PATTERN_INC_EN
        want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'h0000;
`else
        want[0] = 16'hFFFE; want[1] = 16'hFFFE; want[2] = 16'hFFFE;
`endif
        for (int i = 0; i < 3; i++)
            check($sformatf("pattern_%0d", i), 64'(seen[i]), 64'(want[i]));
        @(negedge clk);
        check("pattern_done", {61'd0, test_done, 32'd0 == 32'd0 ? 1'b0 : 1'b1, busy}, 64'd4);

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i], i);

        // Response arriving on the timeout cycle counts as a response
        @(negedge clk);
        mode = 2'b00; timeout_cycles = 16'd3; stim_pattern = 16'h0F0F;
        expect_pattern = 16'h1111; expect_mask = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!dac_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        @(negedge clk);
        adc_valid = 1'b1; adc_data = 16'h1111;
        @(negedge clk);
        adc_valid = 1'b0;
        @(negedge clk);
        check("edge_rsp_iter", 64'(iter_count), 64'd1);
        check("edge_rsp_err", {47'd0, timeout_seen, error_count}, 64'd0);
        check("edge_rsp_done", 64'(test_done), 64'd1);

        // Continuous run with mismatches, abort after 6 iterations
        @(negedge clk);
        mode = 2'b10; timeout_cycles = 16'd0; expect_pattern = 16'h0001; expect_mask = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 300 && iter_count != 32'd6; c++) begin
            @(negedge clk);
            adc_valid = 1'b0;
            if (iter_count != 32'd6 && dac_valid) begin
                adc_valid = 1'b1;
                adc_data  = 16'h0000;
            end
        end
        adc_valid = 1'b0;
        check("cont_iter6", 64'(iter_count), 64'd6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_flags", {60'd0, busy, power_en, test_done, dac_valid}, 64'd0);
        check("abort_err", 64'(error_count), 64'd6);
        check("abort_err_sat", 64'(s_error_count), 64'd3);
        repeat (3) @(negedge clk);
        check("abort_hold_iter", 64'(iter_count), 64'd6);
        check("abort_idle_busy", 64'(busy), 64'd0);

        // Reset asserted while waiting for a response
        mode = 2'b00; stim_pattern = 16'hAAAA; timeout_cycles = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!dac_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("pre_rst_data", 64'(dac_data), 64'hAAAA);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data", {dac_data, iter_count, error_count}, 64'd0);
        check("midrst_flags", {59'd0, dac_valid, power_en, busy, test_done, timeout_seen}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mode = 2'b11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mode11_busy", {62'd0, busy, power_en}, 64'd0);
        repeat (6) @(negedge clk);
        check("mode11_idle", {62'd0, busy, dac_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
